mac_tile_flex: RTL and testbench
================================

MAC_TILE_FLEX -- requirements
Module: mac_tile_flex

Interface
REQ-001 Parameter BW, default 4: activation/weight width.
REQ-002 Parameter PSUM_BW, default 16: partial-sum and accumulator width; SHALL be at least 2*BW+1.
REQ-003 Parameter SAT, default 0: 1 = saturating add, 0 = wrap-around add.
REQ-004 Parameter ROWS, default 8: column height; sets drain length in cycles; SHALL be at least 1.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 mode  input  1  0 = weight-stationary (WS), 1 = output-stationary (OS).
REQ-008 in_w  input  BW  activation from the west, unsigned.
REQ-009 out_e  output  BW  registered activation to the east.
REQ-010 inst_w  input  3  bit 0 kernel load; bit 1 execute; bit 2 drain request.
REQ-011 inst_e  output  3  registered instruction to the east.
REQ-012 in_n  input  PSUM_BW  north partial sum (WS) or drain chain input (OS).
REQ-013 out_s  output  PSUM_BW  registered partial sum (WS) or drain data (OS).
REQ-014 out_s_valid  output  1  out_s carries a valid result this cycle.
REQ-015 wgt_n  input  BW  OS weight from the north, signed.
REQ-016 wgt_s  output  BW  registered OS weight to the south.
REQ-017 drain_busy  output  1  OS drain in progress.
REQ-018 drain_err  output  1  sticky flag: drain request arrived while already draining.

Function
REQ-019 mode_q SHALL be captured from mode on every cycle reset is high and held otherwise; mode changes outside reset have no effect.
REQ-020 Product: zero-extend the activation, multiply by the signed weight, sign-extend the result to PSUM_BW. Sums SHALL clamp to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1] when SAT=1 and wrap modulo 2^PSUM_BW when SAT=0.
REQ-021 out_e SHALL register in_w whenever inst_w[0] or inst_w[1] is set, and hold otherwise.
REQ-022 inst_e[1] and inst_e[2] SHALL register inst_w[1] and inst_w[2] every cycle.
REQ-023 WS FSM states are LOAD and RUN. LOAD exits to RUN on the first cycle with inst_w[0]=1; that cycle latches w_q <= in_w.
REQ-024 Further inst_w[0] cycles in RUN SHALL not change w_q. inst_e[0] SHALL be 0 in LOAD and register inst_w[0] in RUN, so the weight passes to the next tile.
REQ-025 WS execute: on a cycle with inst_w[1]=1 in RUN, the tile SHALL set out_s <= in_n + in_w*w_q and out_s_valid <= 1. Latency is 1 cycle.
REQ-026 WS: on any other cycle, out_s SHALL hold and out_s_valid SHALL be 0. inst_w[1] in LOAD is ignored. inst_w[2] is ignored in WS.
REQ-027 OS: two accumulator banks acc[0..1] and a write pointer wb. On inst_w[1]=1, acc[wb] <= acc[wb] + in_w*wgt_n, and wgt_s <= wgt_n.
REQ-028 OS drain FSM states are IDLE and DRAIN, with counter dcnt.
REQ-029 OS drain start: inst_w[2]=1 in IDLE SHALL cause, on the same edge, out_s <= acc[wb], out_s_valid <= 1, acc[~wb] <= 0, wb <= ~wb, dcnt <= ROWS-1, and a move to DRAIN (or stay in IDLE when ROWS=1).
REQ-030 OS DRAIN: each cycle out_s <= in_n, out_s_valid <= 1, dcnt decrements; the cycle with dcnt=1 returns to IDLE.
REQ-031 OS: accumulation into the new wb SHALL continue uninterrupted during DRAIN, including on the drain-start cycle.
REQ-032 OS: inst_w[2]=1 while in DRAIN SHALL set drain_err=1 and SHALL not alter dcnt, banks or wb.
REQ-033 drain_busy SHALL equal (state==DRAIN). In OS IDLE, out_s_valid SHALL be 0.

Reset
REQ-034 While reset is high, all of the following SHALL be cleared: out_e, inst_e, out_s, out_s_valid, wgt_s, w_q, acc[0], acc[1], wb, dcnt, drain_busy, drain_err.
REQ-035 While reset is high, the WS FSM SHALL go to LOAD and the OS FSM SHALL go to IDLE.
REQ-036 Reset asserted mid-drain or mid-load SHALL abort the operation with no residual output on the following cycle.

Verification (BW=4, PSUM_BW=16, ROWS=4)
REQ-037 WS: load in_w=4'b1101 (-3), then execute with in_w=5, in_n=100 -> next cycle out_s=85, out_s_valid=1.
REQ-038 WS: a second load with in_w=7 -> w_q stays -3, inst_e[0]=1; executing with in_w=1, in_n=0 gives out_s=-3.
REQ-039 OS: 3 execute cycles with in_w=2, wgt_n=3, then drain with in_n=11,12,13 -> out_s sequence 18,11,12,13 with valid high 4 cycles; drain_busy low after.
REQ-040 OS: acc=32760 plus in_w=15, wgt_n=7 -> SAT=1 gives 32767; SAT=0 gives -32671.
REQ-041 OS: drain request during DRAIN -> drain_err=1 sticky, drain ends on schedule; accumulation during drain appears at the next drain.
REQ-042 Reset asserted in drain cycle 2 -> next cycle all outputs 0, drain_busy=0, drain_err=0.

Source files
------------

// File: rtl/mac_tile_flex.sv
// mac_tile_flex: dual-mode systolic MAC tile, weight-stationary or output-stationary
// with double-buffered accumulators drained down a ROWS-deep column chain.
module mac_tile_flex #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int SAT     = 0,
    parameter int ROWS    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [BW-1:0]      in_w,
    output logic [BW-1:0]      out_e,
    input  logic [2:0]         inst_w,
    output logic [2:0]         inst_e,
    input  logic [PSUM_BW-1:0] in_n,
    output logic [PSUM_BW-1:0] out_s,
    output logic               out_s_valid,
    input  logic [BW-1:0]      wgt_n,
    output logic [BW-1:0]      wgt_s,
    output logic               drain_busy,
    output logic               drain_err
);
    localparam int DW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam logic [PSUM_BW-1:0] PMAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic [PSUM_BW-1:0] PMIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    typedef enum logic {LOAD, RUN} ws_t;
    typedef enum logic {IDLE, DRAIN} os_t;

    ws_t ws_q, ws_d;
    os_t os_q, os_d;
    logic mode_q, wb, start, acc_idx;
    logic [BW-1:0] w_q;
    logic [DW-1:0] dcnt;
    logic [PSUM_BW-1:0] acc [2];
    logic [PSUM_BW-1:0] acc_base, ws_sum, os_sum;

    // base + zext(a) * signed(w), sign-extended, then clamped or wrapped
    function automatic logic [PSUM_BW-1:0] mac(input logic [PSUM_BW-1:0] base,
                                               input logic [BW-1:0] a,
                                               input logic [BW-1:0] w);
        logic signed [2*BW:0] p;
        logic signed [PSUM_BW:0] s;
        p = $signed({{BW{1'b0}}, a}) * $signed({{(BW+1){w[BW-1]}}, w});
        s = $signed({base[PSUM_BW-1], base}) + $signed({{(PSUM_BW-2*BW){p[2*BW]}}, p});
        return (SAT != 0 && s[PSUM_BW] != s[PSUM_BW-1]) ? (s[PSUM_BW] ? PMIN : PMAX) : s[PSUM_BW-1:0];
    endfunction

    // the bank being opened by a drain start begins from zero on that same edge
    assign start      = mode_q && os_q == IDLE && inst_w[2];
    assign acc_idx    = start ? ~wb : wb;
    assign acc_base   = start ? '0 : acc[wb];
    assign ws_sum     = mac(in_n, in_w, w_q);
    assign os_sum     = mac(acc_base, in_w, wgt_n);
    assign drain_busy = os_q == DRAIN;

    always_comb begin
        ws_d = (!mode_q && ws_q == LOAD && inst_w[0]) ? RUN : ws_q;
        os_d = os_q;
        if (start && ROWS > 1)
            os_d = DRAIN;
        else if (mode_q && os_q == DRAIN && dcnt == DW'(1))
            os_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= mode;
            ws_q        <= LOAD;
            os_q        <= IDLE;
            out_e       <= '0;
            inst_e      <= '0;
            out_s       <= '0;
            out_s_valid <= 1'b0;
            wgt_s       <= '0;
            w_q         <= '0;
            acc[0]      <= '0;
            acc[1]      <= '0;
            wb          <= 1'b0;
            dcnt        <= '0;
            drain_err   <= 1'b0;
        end else begin
            ws_q        <= ws_d;
            os_q        <= os_d;
            out_s_valid <= 1'b0;
            inst_e      <= {inst_w[2:1], (mode_q || ws_q == RUN) && inst_w[0]};
            if (inst_w[0] || inst_w[1])
                out_e <= in_w;
            if (!mode_q) begin
                if (ws_q == LOAD && inst_w[0])
                    w_q <= in_w;
                if (ws_q == RUN && inst_w[1]) begin
                    out_s       <= ws_sum;
                    out_s_valid <= 1'b1;
                end
            end else begin
                if (start) begin
                    out_s       <= acc[wb];
                    out_s_valid <= 1'b1;
                    acc[~wb]    <= '0;
                    wb          <= ~wb;
                    dcnt        <= DW'(ROWS - 1);
                end else if (os_q == DRAIN) begin
                    out_s       <= in_n;
                    out_s_valid <= 1'b1;
                    dcnt        <= dcnt - 1'b1;
                    if (inst_w[2])
                        drain_err <= 1'b1;
                end
                if (inst_w[1]) begin
                    acc[acc_idx] <= os_sum;
                    wgt_s        <= wgt_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_tile_flex.sv
// tb_mac_tile_flex: directed checks of WS load/execute, OS accumulate/drain,
// saturation vs wrap, drain error and reset abort (BW=4, PSUM_BW=16, ROWS=4).
module tb_mac_tile_flex;
    logic clk = 1'b0;
    logic reset, mode;
    logic [3:0] in_w, wgt_n;
    logic [2:0] inst_w;
    logic [15:0] in_n;
    logic [3:0] u0_out_e, u1_out_e, u0_wgt_s, u1_wgt_s;
    logic [2:0] u0_inst_e, u1_inst_e;
    logic [15:0] u0_out_s, u1_out_s;
    logic u0_valid, u1_valid, u0_busy, u1_busy, u0_err, u1_err;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mac_tile_flex #(.BW(4), .PSUM_BW(16), .SAT(0), .ROWS(4)) u0 (
        .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .out_e(u0_out_e),
        .inst_w(inst_w), .inst_e(u0_inst_e), .in_n(in_n), .out_s(u0_out_s),
        .out_s_valid(u0_valid), .wgt_n(wgt_n), .wgt_s(u0_wgt_s),
        .drain_busy(u0_busy), .drain_err(u0_err));

    mac_tile_flex #(.BW(4), .PSUM_BW(16), .SAT(1), .ROWS(4)) u1 (
        .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .out_e(u1_out_e),
        .inst_w(inst_w), .inst_e(u1_inst_e), .in_n(in_n), .out_s(u1_out_s),
        .out_s_valid(u1_valid), .wgt_n(wgt_n), .wgt_s(u1_wgt_s),
        .drain_busy(u1_busy), .drain_err(u1_err));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic m);
        reset = 1'b1; mode = m; inst_w = 3'b000; in_w = 4'd0; in_n = 16'd0; wgt_n = 4'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 1'b0; inst_w = 3'b111; in_w = 4'd9; in_n = 16'd5; wgt_n = 4'd3;
        tick();
        tick();
        total++; if (u0_out_s !== 16'd0) begin bad++; $display("FAIL reset out_s got=%0h exp=0", u0_out_s); end
        total++; if (u0_valid !== 1'b0) begin bad++; $display("FAIL reset valid got=%0b exp=0", u0_valid); end
        total++; if (u0_out_e !== 4'd0) begin bad++; $display("FAIL reset out_e got=%0h exp=0", u0_out_e); end
        total++; if (u0_inst_e !== 3'b000) begin bad++; $display("FAIL reset inst_e got=%0b exp=000", u0_inst_e); end
        total++; if (u0_wgt_s !== 4'd0) begin bad++; $display("FAIL reset wgt_s got=%0h exp=0", u0_wgt_s); end
        total++; if ({u0_busy, u0_err, u1_busy, u1_err} !== 4'b0000) begin bad++; $display("FAIL reset busy_err got=%0b exp=0000", {u0_busy, u0_err, u1_busy, u1_err}); end
    endtask

    task automatic test_ws_exec();
        do_reset(1'b0);
        inst_w = 3'b010; in_w = 4'd5; in_n = 16'd50;
        tick();
        total++; if (u0_valid !== 1'b0) begin bad++; $display("FAIL ws_exec_in_load valid got=%0b exp=0", u0_valid); end
        total++; if (u0_out_e !== 4'd5) begin bad++; $display("FAIL ws_exec_in_load out_e got=%0d exp=5", u0_out_e); end
        total++; if (u0_inst_e !== 3'b010) begin bad++; $display("FAIL ws_exec_in_load inst_e got=%0b exp=010", u0_inst_e); end
        inst_w = 3'b001; in_w = 4'b1101;
        tick();
        total++; if (u0_out_e !== 4'd13) begin bad++; $display("FAIL ws_load out_e got=%0d exp=13", u0_out_e); end
        total++; if (u0_inst_e !== 3'b000) begin bad++; $display("FAIL ws_load inst_e got=%0b exp=000", u0_inst_e); end
        inst_w = 3'b010; in_w = 4'd5; in_n = 16'd100;
        tick();
        total++; if (u0_out_s !== 16'd85) begin bad++; $display("FAIL ws_exec out_s got=%0d exp=85", u0_out_s); end
        total++; if (u0_valid !== 1'b1) begin bad++; $display("FAIL ws_exec valid got=%0b exp=1", u0_valid); end
        in_w = 4'd0; in_n = 16'd7;
        tick();
        total++; if (u0_out_s !== 16'd7 || u0_valid !== 1'b1) begin bad++; $display("FAIL ws_back_to_back out_s/valid got=%0d/%0b exp=7/1", u0_out_s, u0_valid); end
        inst_w = 3'b000; in_w = 4'd9; in_n = 16'd44;
        tick();
        total++; if (u0_valid !== 1'b0 || u0_out_s !== 16'd7) begin bad++; $display("FAIL ws_hold out_s/valid got=%0d/%0b exp=7/0", u0_out_s, u0_valid); end
        total++; if (u0_out_e !== 4'd0) begin bad++; $display("FAIL ws_hold out_e got=%0d exp=0", u0_out_e); end
    endtask

    task automatic test_ws_reload();
        inst_w = 3'b101; in_w = 4'd7;
        tick();
        total++; if (u0_inst_e !== 3'b101) begin bad++; $display("FAIL ws_reload inst_e got=%0b exp=101", u0_inst_e); end
        total++; if (u0_busy !== 1'b0 || u0_valid !== 1'b0) begin bad++; $display("FAIL ws_drain_ignored busy/valid got=%0b/%0b exp=0/0", u0_busy, u0_valid); end
        mode = 1'b1; inst_w = 3'b010; in_w = 4'd1; in_n = 16'd0;
        tick();
        total++; if (u0_out_s !== 16'hFFFD || u0_valid !== 1'b1) begin bad++; $display("FAIL ws_reload out_s/valid got=%0h/%0b exp=fffd/1", u0_out_s, u0_valid); end
        total++; if (u1_out_s !== 16'hFFFD) begin bad++; $display("FAIL ws_reload_sat out_s got=%0h exp=fffd", u1_out_s); end
        mode = 1'b0;
    endtask

    task automatic test_os_drain();
        logic [15:0] exp_s [4];
        logic exp_b [4];
        exp_s[0] = 16'd18; exp_s[1] = 16'd11; exp_s[2] = 16'd12; exp_s[3] = 16'd13;
        exp_b[0] = 1'b1; exp_b[1] = 1'b1; exp_b[2] = 1'b1; exp_b[3] = 1'b0;
        do_reset(1'b1);
        inst_w = 3'b010; in_w = 4'd2; wgt_n = 4'd3;
        tick();
        total++; if (u0_wgt_s !== 4'd3 || u0_valid !== 1'b0) begin bad++; $display("FAIL os_exec wgt_s/valid got=%0d/%0b exp=3/0", u0_wgt_s, u0_valid); end
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            inst_w = (i == 0) ? 3'b100 : 3'b000;
            in_n = (i == 0) ? 16'd99 : 16'(10 + i);
            tick();
            total++; if (u0_out_s !== exp_s[i] || u0_valid !== 1'b1 || u0_busy !== exp_b[i]) begin bad++; $display("FAIL os_drain[%0d] out_s/valid/busy got=%0d/%0b/%0b exp=%0d/1/%0b", i, u0_out_s, u0_valid, u0_busy, exp_s[i], exp_b[i]); end
        end
        tick();
        total++; if (u0_valid !== 1'b0 || u0_busy !== 1'b0 || u0_err !== 1'b0) begin bad++; $display("FAIL os_drain_end valid/busy/err got=%0b/%0b/%0b exp=0/0/0", u0_valid, u0_busy, u0_err); end
    endtask

    task automatic test_os_sat();
        do_reset(1'b1);
        inst_w = 3'b010; in_w = 4'd15; wgt_n = 4'd7;
        repeat (313) tick();
        inst_w = 3'b100;
        tick();
        total++; if (u0_out_s !== 16'h8061) begin bad++; $display("FAIL os_wrap out_s got=%0h exp=8061", u0_out_s); end
        total++; if (u1_out_s !== 16'h7FFF) begin bad++; $display("FAIL os_sat out_s got=%0h exp=7fff", u1_out_s); end
        inst_w = 3'b000;
    endtask

    task automatic test_drain_err();
        do_reset(1'b1);
        inst_w = 3'b010; in_w = 4'd1; wgt_n = 4'd5;
        tick();
        inst_w = 3'b110; wgt_n = 4'd2;
        tick();
        total++; if (u0_out_s !== 16'd5 || u0_err !== 1'b0) begin bad++; $display("FAIL err_start out_s/err got=%0d/%0b exp=5/0", u0_out_s, u0_err); end
        in_n = 16'd21;
        tick();
        total++; if (u0_out_s !== 16'd21 || u0_err !== 1'b1) begin bad++; $display("FAIL err_set out_s/err got=%0d/%0b exp=21/1", u0_out_s, u0_err); end
        inst_w = 3'b000; in_n = 16'd22;
        tick();
        total++; if (u0_busy !== 1'b1 || u0_err !== 1'b1) begin bad++; $display("FAIL err_sticky busy/err got=%0b/%0b exp=1/1", u0_busy, u0_err); end
        in_n = 16'd23;
        tick();
        total++; if (u0_out_s !== 16'd23 || u0_busy !== 1'b0) begin bad++; $display("FAIL err_schedule out_s/busy got=%0d/%0b exp=23/0", u0_out_s, u0_busy); end
        inst_w = 3'b100;
        tick();
        total++; if (u0_out_s !== 16'd4 || u0_valid !== 1'b1 || u0_err !== 1'b1) begin bad++; $display("FAIL err_next_drain out_s/valid/err got=%0d/%0b/%0b exp=4/1/1", u0_out_s, u0_valid, u0_err); end
    endtask

    task automatic test_reset_mid_drain();
        inst_w = 3'b010; in_w = 4'd3; wgt_n = 4'd3; in_n = 16'd31;
        tick();
        total++; if (u0_out_s !== 16'd31 || u0_busy !== 1'b1) begin bad++; $display("FAIL mid_drain out_s/busy got=%0d/%0b exp=31/1", u0_out_s, u0_busy); end
        reset = 1'b1; mode = 1'b1; inst_w = 3'b000;
        tick();
        total++; if (u0_out_s !== 16'd0 || u0_valid !== 1'b0 || u0_busy !== 1'b0 || u0_err !== 1'b0) begin bad++; $display("FAIL rst_drain out_s/valid/busy/err got=%0d/%0b/%0b/%0b exp=0/0/0/0", u0_out_s, u0_valid, u0_busy, u0_err); end
        total++; if (u0_out_e !== 4'd0 || u0_inst_e !== 3'b000 || u0_wgt_s !== 4'd0) begin bad++; $display("FAIL rst_drain out_e/inst_e/wgt_s got=%0d/%0b/%0d exp=0/000/0", u0_out_e, u0_inst_e, u0_wgt_s); end
        reset = 1'b0;
        tick();
        total++; if (u0_valid !== 1'b0 || u0_busy !== 1'b0) begin bad++; $display("FAIL rst_residual valid/busy got=%0b/%0b exp=0/0", u0_valid, u0_busy); end
        inst_w = 3'b100;
        tick();
        total++; if (u0_out_s !== 16'd0 || u0_valid !== 1'b1 || u0_busy !== 1'b1) begin bad++; $display("FAIL rst_acc_clear out_s/valid/busy got=%0d/%0b/%0b exp=0/1/1", u0_out_s, u0_valid, u0_busy); end
        inst_w = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ws_exec();
        test_ws_reload();
        test_os_drain();
        test_os_sat();
        test_drain_err();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
